// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
// Slot record, arbiter FSM states, grant sides and the open-bus read value.
package cart_mem_pkg;

    localparam int unsigned CART_AW = 22;
    localparam int unsigned CART_DW = 8;

    // Read value returned for accesses the mapper did not permit.
    localparam logic [CART_DW-1:0] OPEN_BUS = 8'hFF;

    // One pending request as latched from the mapper side.
    typedef struct packed {
        logic [CART_AW-1:0] addr;
        logic               we;
        logic [CART_DW-1:0] wdata;
        logic               allow;
        logic               valid;
    } mem_slot_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        GNT_PRG = 1'b0,
        GNT_CHR = 1'b1
    } arb_side_e;

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// External byte-wide memory port: req/ack handshake with address, write and read data.
// master = arbiter side, slave = memory side.
interface cart_mem_arbiter_if
    import cart_mem_pkg::*;
#(
    parameter int unsigned AW = CART_AW,
    parameter int unsigned DW = CART_DW
);

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/cart_req_slot.sv
// One-entry pending request slot for one side (PRG or CHR).
// Captures a request into an empty slot, flags requests that arrive while full,
// frees on completion and presents the registered read data and done strobe.
module cart_req_slot
    import cart_mem_pkg::*;
#(
    parameter int unsigned AW = CART_AW,
    parameter int unsigned DW = CART_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          allow_i,
    input  logic          cmp_i,
    input  logic [DW-1:0] cmp_data_i,
    output mem_slot_t     slot_o,
    output logic [DW-1:0] rdata_o,
    output logic          done_o,
    output logic          ovf_o
);

    mem_slot_t     slot_q, slot_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    // Next-state: completion frees the slot; a request in the same cycle still sees it full.
    always_comb begin
        slot_d  = slot_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        if (cmp_i) begin
            slot_d.valid = 1'b0;
            done_d       = 1'b1;
            if (!slot_q.we) begin
                rdata_d = cmp_data_i;
            end
        end
        if (req_i) begin
            if (slot_q.valid) begin
                ovf_d = 1'b1;
            end else begin
                slot_d.addr  = addr_i;
                slot_d.we    = we_i;
                slot_d.wdata = wdata_i;
                slot_d.allow = allow_i;
                slot_d.valid = 1'b1;
            end
        end
    end

    // Slot state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign slot_o  = slot_q;
    assign rdata_o = rdata_q;
    assign done_o  = done_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/cart_mem_arbiter.sv
// Arbitrates the mapper's PRG (CPU) and CHR (PPU) requests onto one external
// byte-wide memory port. Disallowed accesses complete locally without touching memory.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise CHR has
// fixed priority over PRG (PPU fetches are hard real-time).
module cart_mem_arbiter
    import cart_mem_pkg::*;
#(
    parameter int unsigned AW = CART_AW,
    parameter int unsigned DW = CART_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prg_req,
    input  logic [AW-1:0] prg_addr,
    input  logic          prg_we,
    input  logic [DW-1:0] prg_wdata,
    input  logic          prg_allow,
    output logic [DW-1:0] prg_rdata,
    output logic          prg_done,
    output logic          prg_ovf,
    input  logic          chr_req,
    input  logic [AW-1:0] chr_addr,
    input  logic          chr_we,
    input  logic [DW-1:0] chr_wdata,
    input  logic          chr_allow,
    output logic [DW-1:0] chr_rdata,
    output logic          chr_done,
    output logic          chr_ovf,
    cart_mem_arbiter_if.master mem
);

    mem_slot_t     prg_slot, chr_slot;
    arb_state_e    state_q;
    arb_side_e     gnt_q;
    logic          mem_req_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;
`ifdef ARB_RR_EN
    arb_side_e     last_q;
`endif

    arb_side_e     pick;
    logic          pick_allow;
    logic          grant_now;
    logic          blocked;
    logic          mem_fin;
    logic          prg_cmp, chr_cmp;
    logic [DW-1:0] cmp_data;

    cart_req_slot #(.AW(AW), .DW(DW)) u_prg_slot (
        .clk        (clk),
        .reset      (reset),
        .req_i      (prg_req),
        .addr_i     (prg_addr),
        .we_i       (prg_we),
        .wdata_i    (prg_wdata),
        .allow_i    (prg_allow),
        .cmp_i      (prg_cmp),
        .cmp_data_i (cmp_data),
        .slot_o     (prg_slot),
        .rdata_o    (prg_rdata),
        .done_o     (prg_done),
        .ovf_o      (prg_ovf)
    );

    cart_req_slot #(.AW(AW), .DW(DW)) u_chr_slot (
        .clk        (clk),
        .reset      (reset),
        .req_i      (chr_req),
        .addr_i     (chr_addr),
        .we_i       (chr_we),
        .wdata_i    (chr_wdata),
        .allow_i    (chr_allow),
        .cmp_i      (chr_cmp),
        .cmp_data_i (cmp_data),
        .slot_o     (chr_slot),
        .rdata_o    (chr_rdata),
        .done_o     (chr_done),
        .ovf_o      (chr_ovf)
    );

    // Choose which occupied slot would be granted this cycle.
    always_comb begin
`ifdef ARB_RR_EN
        if (prg_slot.valid && chr_slot.valid) begin
            pick = (last_q == GNT_CHR) ? GNT_PRG : GNT_CHR;
        end else begin
            pick = chr_slot.valid ? GNT_CHR : GNT_PRG;
        end
`else
        pick = chr_slot.valid ? GNT_CHR : GNT_PRG;
`endif
        pick_allow = (pick == GNT_CHR) ? chr_slot.allow : prg_slot.allow;
    end

    // Completion events: a blocked grant in IDLE, or the memory ack in BUSY.
    always_comb begin
        grant_now = (state_q == IDLE) && (prg_slot.valid || chr_slot.valid);
        blocked   = grant_now && !pick_allow;
        mem_fin   = (state_q == BUSY) && mem.mem_ack;
        prg_cmp   = (blocked && (pick == GNT_PRG)) || (mem_fin && (gnt_q == GNT_PRG));
        chr_cmp   = (blocked && (pick == GNT_CHR)) || (mem_fin && (gnt_q == GNT_CHR));
        cmp_data  = (state_q == BUSY) ? mem.mem_rdata : OPEN_BUS;
    end

    // Arbiter FSM with registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_PRG;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
`ifdef ARB_RR_EN
            last_q      <= GNT_PRG;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_now) begin
                        gnt_q <= pick;
`ifdef ARB_RR_EN
                        last_q <= pick;
`endif
                        if (pick_allow) begin
                            mem_req_q <= 1'b1;
                            state_q   <= BUSY;
                            if (pick == GNT_CHR) begin
                                mem_addr_q  <= chr_slot.addr;
                                mem_we_q    <= chr_slot.we;
                                mem_wdata_q <= chr_slot.wdata;
                            end else begin
                                mem_addr_q  <= prg_slot.addr;
                                mem_we_q    <= prg_slot.we;
                                mem_wdata_q <= prg_slot.wdata;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: directed timing cases plus a
// randomized phase checked against a transaction-level reference model.
module tb_cart_mem_arbiter;

    localparam int AW = 22;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          prg_req, prg_we, prg_allow;
    logic [AW-1:0] prg_addr;
    logic [DW-1:0] prg_wdata;
    logic [DW-1:0] prg_rdata;
    logic          prg_done, prg_ovf;
    logic          chr_req, chr_we, chr_allow;
    logic [AW-1:0] chr_addr;
    logic [DW-1:0] chr_wdata;
    logic [DW-1:0] chr_rdata;
    logic          chr_done, chr_ovf;

    cart_mem_arbiter_if #(.AW(AW), .DW(DW)) mem_if ();

    cart_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .prg_req   (prg_req),
        .prg_addr  (prg_addr),
        .prg_we    (prg_we),
        .prg_wdata (prg_wdata),
        .prg_allow (prg_allow),
        .prg_rdata (prg_rdata),
        .prg_done  (prg_done),
        .prg_ovf   (prg_ovf),
        .chr_req   (chr_req),
        .chr_addr  (chr_addr),
        .chr_we    (chr_we),
        .chr_wdata (chr_wdata),
        .chr_allow (chr_allow),
        .chr_rdata (chr_rdata),
        .chr_done  (chr_done),
        .chr_ovf   (chr_ovf),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: acks after ack_delay cycles of mem_req, returns random read data.
    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t        log_q[$];
    int unsigned ack_delay  = 1;
    bit          stray_req  = 1'b0;

    initial begin : responder
        int unsigned   busy_cnt;
        logic [30:0]   hold;
        txn_t          t;
        busy_cnt          = 0;
        hold              = '0;
        mem_if.mem_ack    = 1'b0;
        mem_if.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_if.mem_ack = 1'b0;
            if (stray_req && !mem_if.mem_req) begin
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = 8'h3C;
                busy_cnt         = 0;
            end else if (mem_if.mem_req) begin
                if (busy_cnt == 0) begin
                    hold = {mem_if.mem_addr, mem_if.mem_we, mem_if.mem_wdata};
                end else begin
                    check_eq("mem_stable", {1'b0, mem_if.mem_addr, mem_if.mem_we, mem_if.mem_wdata},
                             {1'b0, hold});
                end
                if (busy_cnt == ack_delay) begin
                    t.addr           = mem_if.mem_addr;
                    t.we             = mem_if.mem_we;
                    t.wdata          = mem_if.mem_wdata;
                    t.rdata          = DW'($urandom);
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = t.rdata;
                    log_q.push_back(t);
                end
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p_cnt, c_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step();
        if (prg_done) p_cnt++;
        if (chr_done) c_cnt++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        prg_req = 1'b0;
        chr_req = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive_prg(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d, input logic al);
        prg_req = 1'b1; prg_addr = a; prg_we = we; prg_wdata = d; prg_allow = al;
    endtask

    task automatic drive_chr(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d, input logic al);
        chr_req = 1'b1; chr_addr = a; chr_we = we; chr_wdata = d; chr_allow = al;
    endtask

    task automatic wait_dones(input string tag, input int unsigned budget, input int need_p, input int need_c);
        for (int unsigned k = 0; k < budget; k++) begin
            if (p_cnt >= need_p && c_cnt >= need_c) break;
            tick();
        end
        check_eq(tag, {31'd0, (p_cnt >= need_p && c_cnt >= need_c)}, 32'd1);
    endtask

    initial begin : main
        logic [AW-1:0] a_p, a_c, a_i;
        logic [DW-1:0] prev, exp_rd_p, exp_rd_c;
        bit            seen;
        bit            use_p, use_c, we_p, we_c, al_p, al_c, chr_first, last_chr;
        bit            ovf_p, ovf_c;
        logic [DW-1:0] d_p, d_c;
        int            n_exp, idx;

        reset = 1'b0;
        prg_req = 1'b0; prg_addr = '0; prg_we = 1'b0; prg_wdata = '0; prg_allow = 1'b0;
        chr_req = 1'b0; chr_addr = '0; chr_we = 1'b0; chr_wdata = '0; chr_allow = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_outputs", {prg_rdata, chr_rdata, prg_done, chr_done, prg_ovf, chr_ovf}, '0);
        check_eq("rst_mem", {mem_if.mem_req, mem_if.mem_we, mem_if.mem_wdata}, '0);
        check_eq("rst_mem_addr", mem_if.mem_addr, '0);

        // PRG read with 3-cycle ack latency
        ack_delay = 3;
        log_q.delete();
        drive_prg(22'h012345, 1'b0, 8'h00, 1'b1);
        step(); prg_req = 1'b0;
        check_eq("t1_req_lat1", mem_if.mem_req, 0);
        step();
        check_eq("t1_req_lat2", mem_if.mem_req, 1);
        check_eq("t1_addr", mem_if.mem_addr, 22'h012345);
        check_eq("t1_we", mem_if.mem_we, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_no_done_yet", prg_done, 0);
        end
        step();
        check_eq("t1_done", prg_done, 1);
        check_eq("t1_req_drop", mem_if.mem_req, 0);
        check_eq("t1_ntxn", log_q.size(), 1);
        if (log_q.size() > 0) check_eq("t1_rdata", prg_rdata, log_q[0].rdata);
        step();
        check_eq("t1_done_strobe", prg_done, 0);

        // Simultaneous requests: CHR first; PRG mem_req two cycles after CHR ack
        ack_delay = 2;
        log_q.delete();
        drive_prg(22'h0AAAAA, 1'b0, 8'h00, 1'b1);
        drive_chr(22'h155555, 1'b0, 8'h00, 1'b1);
        step(); prg_req = 1'b0; chr_req = 1'b0;
        step();
        check_eq("t2_first_addr", mem_if.mem_addr, 22'h155555);
        step(); step(); step();
        check_eq("t2_chr_done", chr_done, 1);
        check_eq("t2_gap", mem_if.mem_req, 0);
        step();
        check_eq("t2_prg_req", mem_if.mem_req, 1);
        check_eq("t2_prg_addr", mem_if.mem_addr, 22'h0AAAAA);
        p_cnt = 0; c_cnt = 0;
        wait_dones("t2_prg_timeout", 20, 1, 0);
        if (log_q.size() == 2) begin
            check_eq("t2_chr_rdata", chr_rdata, log_q[0].rdata);
            check_eq("t2_prg_rdata", prg_rdata, log_q[1].rdata);
        end else begin
            check_eq("t2_ntxn", log_q.size(), 2);
        end

        // CHR alone (last grant becomes CHR), then both together
        drive_chr(22'h000111, 1'b0, 8'h00, 1'b1);
        step(); chr_req = 1'b0;
        p_cnt = 0; c_cnt = 0;
        wait_dones("t2b_timeout", 20, 0, 1);
        step();
        drive_prg(22'h000222, 1'b0, 8'h00, 1'b1);
        drive_chr(22'h000333, 1'b0, 8'h00, 1'b1);
        step(); prg_req = 1'b0; chr_req = 1'b0;
        step();
`ifdef ARB_RR_EN
        check_eq("t2_rr_first", mem_if.mem_addr, 22'h000222);
`else
        check_eq("t2_fixed_first", mem_if.mem_addr, 22'h000333);
`endif
        p_cnt = 0; c_cnt = 0;
        wait_dones("t2c_timeout", 30, 1, 1);
        step();

        // Disallowed write then disallowed read
        log_q.delete();
        prev = prg_rdata;
        seen = 1'b0;
        drive_prg(22'h3FFFFF, 1'b1, 8'h5A, 1'b0);
        step(); prg_req = 1'b0;
        seen |= mem_if.mem_req;
        step();
        seen |= mem_if.mem_req;
        check_eq("t3_wr_done", prg_done, 1);
        check_eq("t3_wr_rdata", prg_rdata, prev);
        drive_prg(22'h200000, 1'b0, 8'h00, 1'b0);
        step(); prg_req = 1'b0;
        seen |= mem_if.mem_req;
        step();
        seen |= mem_if.mem_req;
        check_eq("t3_rd_done", prg_done, 1);
        check_eq("t3_rd_rdata", prg_rdata, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= mem_if.mem_req;
        end
        check_eq("t3_no_mem_req", seen, 0);
        check_eq("t3_ntxn", log_q.size(), 0);

        // Overflow: second PRG request while pending
        ack_delay = 4;
        log_q.delete();
        drive_prg(22'h001000, 1'b0, 8'h00, 1'b1);
        step();
        drive_prg(22'h002000, 1'b0, 8'h00, 1'b1);
        step(); prg_req = 1'b0;
        check_eq("t4_ovf_set", prg_ovf, 1);
        p_cnt = 0; c_cnt = 0;
        wait_dones("t4_timeout", 20, 1, 0);
        for (int i = 0; i < 6; i++) step();
        check_eq("t4_one_txn", log_q.size(), 1);
        if (log_q.size() > 0) check_eq("t4_txn_addr", log_q[0].addr, 22'h001000);
        check_eq("t4_ovf_sticky", prg_ovf, 1);
        check_eq("t4_chr_ovf", chr_ovf, 0);
        do_reset();
        check_eq("t4_ovf_cleared", prg_ovf, 0);

        // Reset while BUSY, then a stray ack
        ack_delay = 50;
        drive_chr(22'h0ABCDE, 1'b0, 8'h00, 1'b1);
        step(); chr_req = 1'b0;
        step();
        check_eq("t5_busy", mem_if.mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t5_req_low", mem_if.mem_req, 0);
        check_eq("t5_no_done", {prg_done, chr_done}, 0);
        stray_req = 1'b1;
        step();
        stray_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= (mem_if.mem_req | prg_done | chr_done);
        end
        check_eq("t5_quiet", seen, 0);

        // 100 CHR reads, 1-cycle ack, spaced >= 4 cycles
        do_reset();
        ack_delay = 1;
        log_q.delete();
        for (int i = 0; i < 100; i++) begin
            a_i = AW'($urandom);
            drive_chr(a_i, 1'b0, 8'h00, 1'b1);
            step(); chr_req = 1'b0;
            step(); step();
            check_eq("t6_not_early", chr_done, 0);
            step();
            check_eq("t6_done", chr_done, 1);
            if (log_q.size() == i + 1) begin
                check_eq("t6_addr", log_q[i].addr, a_i);
                check_eq("t6_rdata", chr_rdata, log_q[i].rdata);
            end else begin
                check_eq("t6_ntxn", log_q.size(), i + 1);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
        check_eq("t6_no_ovf", chr_ovf, 0);

        // Randomized phase against a transaction-level reference model
        do_reset();
        log_q.delete();
        last_chr = 1'b0;
        ovf_p = 1'b0; ovf_c = 1'b0;
        exp_rd_p = '0; exp_rd_c = '0;
        for (int op = 0; op < 40; op++) begin
            ack_delay = $urandom_range(0, 3);
            idx   = $urandom_range(1, 3);
            use_p = idx[0]; use_c = idx[1];
            a_p = AW'($urandom); a_c = AW'($urandom);
            we_p = 1'($urandom); we_c = 1'($urandom);
            d_p = DW'($urandom); d_c = DW'($urandom);
            al_p = ($urandom_range(0, 3) != 0);
            al_c = ($urandom_range(0, 3) != 0);
            p_cnt = 0; c_cnt = 0;
            if (use_p) drive_prg(a_p, we_p, d_p, al_p);
            if (use_c) drive_chr(a_c, we_c, d_c, al_c);
            tick(); prg_req = 1'b0; chr_req = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                if (use_p) begin drive_prg(~a_p, 1'b0, 8'h00, 1'b1); ovf_p = 1'b1; end
                else       begin drive_chr(~a_c, 1'b0, 8'h00, 1'b1); ovf_c = 1'b1; end
                tick(); prg_req = 1'b0; chr_req = 1'b0;
            end
            wait_dones("rnd_timeout", 40, int'(use_p), int'(use_c));
            tick();
            check_eq("rnd_done_count", {p_cnt[15:0], c_cnt[15:0]}, {15'd0, use_p, 15'd0, use_c});

`ifdef ARB_RR_EN
            chr_first = use_c && (!use_p || !last_chr);
`else
            chr_first = use_c;
`endif
            n_exp = 0;
            for (int k = 0; k < 2; k++) begin
                bit is_chr;
                is_chr = (k == 0) ? chr_first : !chr_first;
                if (is_chr ? !use_c : !use_p) continue;
                last_chr = is_chr;
                if (is_chr ? !al_c : !al_p) begin
                    if (is_chr && !we_c) exp_rd_c = 8'hFF;
                    if (!is_chr && !we_p) exp_rd_p = 8'hFF;
                end else begin
                    if (log_q.size() > n_exp) begin
                        check_eq("rnd_txn_addr", log_q[n_exp].addr, is_chr ? a_c : a_p);
                        check_eq("rnd_txn_we", log_q[n_exp].we, is_chr ? we_c : we_p);
                        if (is_chr ? we_c : we_p)
                            check_eq("rnd_txn_wdata", log_q[n_exp].wdata, is_chr ? d_c : d_p);
                        else if (is_chr)
                            exp_rd_c = log_q[n_exp].rdata;
                        else
                            exp_rd_p = log_q[n_exp].rdata;
                    end
                    n_exp++;
                end
            end
            check_eq("rnd_ntxn", log_q.size(), n_exp);
            check_eq("rnd_prg_rdata", prg_rdata, exp_rd_p);
            check_eq("rnd_chr_rdata", chr_rdata, exp_rd_c);
            check_eq("rnd_ovf", {prg_ovf, chr_ovf}, {ovf_p, ovf_c});
            log_q.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Sits directly downstream of the cartridge mapper.
- Takes the mapper's translated PRG (CPU) and CHR (PPU) addresses and allow qualifiers, and arbitrates them onto one external byte-wide memory port with a req/ack handshake.
- Holds a one-entry pending slot per side, returns read data and a one-cycle done strobe per request, and blocks disallowed accesses from reaching memory.

Parameters:
- AW, 22, address width; matches the mapper's prg_aout/chr_aout.
- DW, 8, data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- prg_req  in  1  one-cycle request pulse from the CPU side
- prg_addr  in  AW  mapper PRG output address
- prg_we  in  1  1 = write, 0 = read
- prg_wdata  in  DW  write data
- prg_allow  in  1  mapper permission for this PRG access
- prg_rdata  out  DW  read data, held until the next PRG completion
- prg_done  out  1  one-cycle completion strobe
- prg_ovf  out  1  sticky: a request arrived while the PRG slot was occupied
- chr_req, chr_addr, chr_we, chr_wdata, chr_allow, chr_rdata, chr_done, chr_ovf: same meanings for the PPU side
- mem_req  out  1  held high until mem_ack
- mem_addr  out  AW  external memory address
- mem_we  out  1  external write enable
- mem_wdata  out  DW  external write data
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  DW  external read data

Behaviour:
- Reset values: all outputs 0, both slots empty, FSM in IDLE, last-grant = PRG.
- Capture: a req seen at cycle N with an empty slot loads {addr, we, wdata, allow} into that slot at N+1.
  - A req seen while the slot is full is dropped and sets the side's _ovf flag. The flag clears only on reset.
- Disallowed access: a slot holding allow=0 never reaches memory.
  - It completes at the first cycle it would otherwise be granted: _done=1 and the slot frees.
  - For a read, _rdata becomes 8'hFF. For a write, _rdata is unchanged.
  - This path still consumes the grant cycle.
- FSM states:
  - IDLE: if any slot is occupied, grant one. Drive mem_req/addr/we/wdata from that slot on the next edge and move to BUSY.
  - BUSY: hold all mem_* outputs stable until mem_ack. On mem_ack:
    - deassert mem_req on the next edge;
    - for a read, capture mem_rdata into the granted side's _rdata;
    - pulse that side's _done on the next edge;
    - free the slot and return to IDLE.
  - Any completion returns to IDLE, and the next grant happens at the earliest one cycle later. mem_req is therefore low for at least one cycle between transactions.
- Latency: req at N, with memory idle, gives mem_req at N+2. An ack at M gives _done and _rdata valid at M+1.
- Arbitration default: fixed priority, CHR wins over PRG when both slots are occupied. The PPU fetch cadence is hard real-time.
- Simultaneous events:
  - A new req on the side whose slot is completing in the same cycle is treated as a slot-full drop. The slot frees one cycle later.
  - Requests on both sides in the same cycle are both captured.
- mem_ack while in IDLE is ignored.
- Reset mid-transaction: mem_req drops on the next edge, slots clear, and no _done is issued. The memory side must tolerate an abandoned request.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration. When both slots are occupied, grant the side that did not hold the last grant. Last-grant updates on every grant, including disallowed completions.
- ARB_RR_EN undefined: fixed CHR-over-PRG priority. Last-grant register is absent.

Decomposition:
- Package cart_mem_pkg:
  - typedef mem_slot_t {addr, we, wdata, allow, valid};
  - enum arb_state_e {IDLE, BUSY};
  - constant OPEN_BUS = 8'hFF.
- One sub-module, cart_req_slot, instantiated twice. It handles capture, the ovf flag, free-on-complete, and the registered rdata/done outputs.
- The FSM and grant logic stay in the top module.

Test Plan:
- PRG read, addr 22'h012345, allow=1, memory acks 3 cycles after mem_req -> mem_addr = 22'h012345, mem_we=0; prg_done one cycle after ack with prg_rdata = the acked mem_rdata (e.g. 8'hA5).
- prg_req and chr_req in the same cycle, fixed priority -> CHR transaction first. PRG mem_req rises 2 cycles after CHR's ack. Under ARB_RR_EN with last grant = CHR, PRG goes first.
- PRG write with allow=0 -> mem_req never asserted; prg_done pulses; prg_rdata unchanged. Same case as a read -> prg_rdata = 8'hFF.
- Second prg_req while the first is pending -> prg_ovf=1 and stays set. Only one memory transaction occurs; after reset, prg_ovf=0.
- Reset asserted while BUSY -> mem_req low next cycle, no done pulses, slots empty. A later ack is ignored.
- 100 back-to-back CHR reads with 1-cycle ack -> every request completes in order with no ovf, provided requests are spaced at least 4 cycles apart.
